// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// Package     : debounce_pkg
// Description : State encoding and parameter floors shared by d_debounce.
// Revision    : 1.0
// ============================================================================
package debounce_pkg;

   typedef enum logic [1:0] {
      ST_LOW    = 2'd0,
      ST_WAIT_H = 2'd1,
      ST_HIGH   = 2'd2,
      ST_WAIT_L = 2'd3
   } state_t;

   localparam int MIN_SYNC_STAGES     = 2;
   localparam int MIN_DEBOUNCE_CYCLES = 2;

endpackage
`default_nettype wire

// File: rtl/d_debounce_sync_chain.sv
`default_nettype none
// ============================================================================
// Module      : sync_chain
// Description : N-stage resettable single-bit synchronizer.
// Revision    : 1.0
// ============================================================================
module sync_chain #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic dout
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], din};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign dout = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/d_debounce.sv
`default_nettype none
// ============================================================================
// Module      : d_debounce
// Description : Synchronizes and debounces a push button, giving a level (or,
//               with DEBOUNCE_TOGGLE_EN defined, a toggle) plus edge pulses.
// Revision    : 1.0
// ============================================================================
module d_debounce
   import debounce_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic d,
   output logic rise_pulse,
   output logic fall_pulse
);

   localparam int SYNC_N = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;
   localparam int DEB_N  = (DEBOUNCE_CYCLES < MIN_DEBOUNCE_CYCLES) ? MIN_DEBOUNCE_CYCLES
                                                                    : DEBOUNCE_CYCLES;
   localparam int CNT_W  = $clog2(DEB_N);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_N - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             s;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             d_q, d_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
   logic             illegal;

   sync_chain #(.STAGES(SYNC_N)) u_sync (
      .clk   (clk),
      .reset (reset),
      .din   (btn_raw),
      .dout  (s)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      illegal = 1'b0;
      case (state_q)
         ST_LOW: begin
            if (s) begin
               state_d = ST_WAIT_H;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d = '0;
            end
         end
         ST_WAIT_H: begin
            if (!s) begin
               state_d = ST_LOW;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_HIGH;
               cnt_d   = '0;
               rise_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_HIGH: begin
            if (!s) begin
               state_d = ST_WAIT_L;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d = '0;
            end
         end
         ST_WAIT_L: begin
            if (s) begin
               state_d = ST_HIGH;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_LOW;
               cnt_d   = '0;
               fall_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = ST_LOW;
            cnt_d   = '0;
            illegal = 1'b1;
         end
      endcase
   end

   // Output level: debounced level, or a flop that flips on each accepted press.
   always_comb begin
      d_d = d_q;
      if (illegal) begin
         d_d = 1'b0;
      end else begin
`ifdef DEBOUNCE_TOGGLE_EN
         if (rise_d) begin
            d_d = ~d_q;
         end
`else
         if (rise_d) begin
            d_d = 1'b1;
         end else if (fall_d) begin
            d_d = 1'b0;
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_LOW;
         cnt_q   <= '0;
         d_q     <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         d_q     <= d_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign d          = d_q;
   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;

endmodule
`default_nettype wire

// File: tb/tb_d_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_d_debounce
// Description : Directed, table-driven bench for d_debounce (defaults 2/4).
// Revision    : 1.0
// ============================================================================
module tb_d_debounce;

   logic clk = 1'b0;
   logic reset;
   logic btn_raw;
   logic d;
   logic rise_pulse;
   logic fall_pulse;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic btn;
      logic d;
      logic rise;
      logic fall;
   } vec_t;

   localparam int NVEC = 50;
   vec_t vecs [NVEC];
   logic exp_d;

   always #5 clk = ~clk;

   d_debounce #(
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .btn_raw    (btn_raw),
      .d          (d),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse)
   );

   task automatic check(input string name, input logic [2:0] act, input logic [2:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual={d,rise,fall}=%b required=%b", name, act, req);
      end
   endtask

   task automatic check_state(input string name, input logic [1:0] act, input logic [1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic tick(input logic b);
      btn_raw = b;
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input int lo, input int hi, input logic b, input logic dd,
                       input logic r, input logic f);
      for (int i = lo; i <= hi; i++) begin
         vecs[i].btn  = b;
         vecs[i].d    = dd;
         vecs[i].rise = r;
         vecs[i].fall = f;
      end
   endtask

   task automatic clean_reset();
      reset = 1'b1;
      tick(1'b0);
      tick(1'b0);
      reset = 1'b0;
      tick(1'b0);
      tick(1'b0);
   endtask

   // Press held for six edges: the sixth edge carries the rise pulse.
   task automatic press(input string name, input logic d_before, input logic d_after);
      for (int k = 1; k <= 6; k++) begin
         tick(1'b1);
         if (k < 6) check(name, {d, rise_pulse, fall_pulse}, {d_before, 2'b00});
         else       check(name, {d, rise_pulse, fall_pulse}, {d_after, 2'b10});
      end
   endtask

   task automatic release_btn(input string name, input logic d_before, input logic d_after);
      for (int k = 1; k <= 6; k++) begin
         tick(1'b0);
         if (k < 6) check(name, {d, rise_pulse, fall_pulse}, {d_before, 2'b00});
         else       check(name, {d, rise_pulse, fall_pulse}, {d_after, 2'b01});
      end
   endtask

   always @(negedge clk) begin
      if (rise_pulse && fall_pulse) begin
         checks++;
         failures++;
         $display("FAIL pulse_exclusive actual=rise&fall required=not both");
      end
   end

   initial begin
      // Clean press, release, short bounce, restart bounce, final release.
      fill( 0,  4, 1'b1, 1'b0, 1'b0, 1'b0);
      fill( 5,  5, 1'b1, 1'b1, 1'b1, 1'b0);
      fill( 6,  9, 1'b1, 1'b1, 1'b0, 1'b0);
      fill(10, 14, 1'b0, 1'b1, 1'b0, 1'b0);
      fill(15, 15, 1'b0, 1'b0, 1'b0, 1'b1);
      fill(16, 19, 1'b0, 1'b0, 1'b0, 1'b0);
      fill(20, 22, 1'b1, 1'b0, 1'b0, 1'b0);
      fill(23, 29, 1'b0, 1'b0, 1'b0, 1'b0);
      fill(30, 30, 1'b1, 1'b0, 1'b0, 1'b0);
      fill(31, 31, 1'b0, 1'b0, 1'b0, 1'b0);
      fill(32, 36, 1'b1, 1'b0, 1'b0, 1'b0);
      fill(37, 37, 1'b1, 1'b1, 1'b1, 1'b0);
      fill(38, 39, 1'b1, 1'b1, 1'b0, 1'b0);
      fill(40, 44, 1'b0, 1'b1, 1'b0, 1'b0);
      fill(45, 45, 1'b0, 1'b0, 1'b0, 1'b1);
      fill(46, 49, 1'b0, 1'b0, 1'b0, 1'b0);

      // Reset held with button high, then rise on the sixth edge after release.
      reset = 1'b1;
      for (int k = 0; k < 2; k++) begin
         tick(1'b1);
         check("reset_hold", {d, rise_pulse, fall_pulse}, 3'b000);
      end
      reset = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         tick(1'b1);
         if (k < 6) check("post_reset_wait", {d, rise_pulse, fall_pulse}, 3'b000);
         else       check("post_reset_rise", {d, rise_pulse, fall_pulse}, 3'b110);
      end

      clean_reset();
      exp_d = 1'b0;
      for (int i = 0; i < NVEC; i++) begin
         tick(vecs[i].btn);
`ifdef DEBOUNCE_TOGGLE_EN
         if (vecs[i].rise) exp_d = ~exp_d;
`else
         exp_d = vecs[i].d;
`endif
         check($sformatf("vec%0d", i), {d, rise_pulse, fall_pulse},
               {exp_d, vecs[i].rise, vecs[i].fall});
      end
      check_state("bounce_state", dut.state_q, debounce_pkg::ST_LOW);

      // Reset in ST_WAIT_H with a partial count of 2.
      for (int k = 0; k < 4; k++) tick(1'b1);
      check_state("wait_h_state", dut.state_q, debounce_pkg::ST_WAIT_H);
      check_state("wait_h_cnt", 2'(dut.cnt_q), 2'd2);
      reset = 1'b1;
      tick(1'b1);
      check("mid_wait_reset", {d, rise_pulse, fall_pulse}, 3'b000);
      check_state("mid_wait_reset_state", dut.state_q, debounce_pkg::ST_LOW);
      reset = 1'b0;
      press("restart_after_reset", 1'b0, 1'b1);

      // Three clean presses: level follows button, toggle flips per press.
      clean_reset();
`ifdef DEBOUNCE_TOGGLE_EN
      press("toggle_p1", 1'b0, 1'b1);
      release_btn("toggle_r1", 1'b1, 1'b1);
      press("toggle_p2", 1'b1, 1'b0);
      release_btn("toggle_r2", 1'b0, 1'b0);
      press("toggle_p3", 1'b0, 1'b1);
      release_btn("toggle_r3", 1'b1, 1'b1);
`else
      for (int p = 0; p < 3; p++) begin
         press("level_press", 1'b0, 1'b1);
         release_btn("level_release", 1'b1, 1'b0);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
